// File: rtl/icu_wide.sv
// icu_wide -- one-bit-style industrial control unit with a WIDTH-bit data path.
//
// Purpose: executes one 4-bit instruction per clock.  Logic ops act on the
// result register RR, stores go to data_out, and jumps/returns move the pc.
// IEN gates the input data and OEN gates stores.  SKZ discards the next
// instruction when RR is all zeros.
//
// Optional feature: define ICU_WIDE_STACK_EN to build a STACK_DEPTH-entry
// return-address stack.  The default build has no stack: JMP only loads pc,
// RTN steps pc and skips the next instruction, and stack_ovf/stack_unf are 0.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   i         opcode (instructions::instruction_t)
//   addr_in   JMP target
//   data_in   input data bus
//   data_out  stored data (registered)
//   write     one-cycle store strobe
//   pc        program counter
//   jmp, rtn  one-cycle JMP / RTN pulses
//   flag_o    one-cycle NOPO pulse
//   flag_f    one-cycle NOPF pulse
//   rr_out    result register
//   stack_ovf sticky stack overflow
//   stack_unf sticky stack underflow

package instructions;
  typedef enum logic [3:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;
endpackage

module icu_wide
  import instructions::*;
#(
  parameter int WIDTH       = 4,
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  instruction_t        i,
  input  logic [PC_WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0]    data_in,
  output logic [WIDTH-1:0]    data_out,
  output logic                write,
  output logic [PC_WIDTH-1:0] pc,
  output logic                jmp,
  output logic                rtn,
  output logic                flag_o,
  output logic                flag_f,
  output logic [WIDTH-1:0]    rr_out,
  output logic                stack_ovf,
  output logic                stack_unf
);

  if (WIDTH < 1 || PC_WIDTH < 1 || STACK_DEPTH < 1) begin : g_bad_cfg
    $error("icu_wide: WIDTH, PC_WIDTH and STACK_DEPTH must all be >= 1");
  end

  logic [WIDTH-1:0]    rr;
  logic [WIDTH-1:0]    d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                ien;
  logic                oen;
  logic                skip;

  assign rr_out = rr;

  always_comb begin
    d      = ien ? data_in : '0;
    pc_inc = pc + PC_WIDTH'(1);
  end

`ifdef ICU_WIDE_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [SP_W-1:0]     sp;
  logic [SP_W-1:0]     pop_idx;
  logic                stack_full;
  logic                stack_empty;
  logic                push;
  // Sized to the full sp range so sp indexes it directly; entries at or
  // above STACK_DEPTH are never written and are trimmed in synthesis.
  logic [PC_WIDTH-1:0] stack_mem [2**SP_W];

  always_comb begin
    stack_full  = (sp == SP_W'(STACK_DEPTH));
    stack_empty = (sp == '0);
    pop_idx     = sp - SP_W'(1);
    push        = !skip && (i == JMP) && !stack_full;
  end

  // Storage needs no reset: the cleared stack pointer marks it empty.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp] <= pc_inc;
  end
`else
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr        <= '0;
      data_out  <= '0;
      ien       <= 1'b0;
      oen       <= 1'b0;
      pc        <= '0;
      skip      <= 1'b0;
      write     <= 1'b0;
      jmp       <= 1'b0;
      rtn       <= 1'b0;
      flag_o    <= 1'b0;
      flag_f    <= 1'b0;
`ifdef ICU_WIDE_STACK_EN
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
`endif
    end else begin
      write  <= 1'b0;
      jmp    <= 1'b0;
      rtn    <= 1'b0;
      flag_o <= 1'b0;
      flag_f <= 1'b0;
      pc     <= pc_inc;
      skip   <= 1'b0;
      // A skipped instruction only advances pc; it cannot re-arm the skip.
      if (!skip) begin
        case (i)
          NOPO: flag_o <= 1'b1;
          LD:   rr <= d;
          LDC:  rr <= ~d;
          AND:  rr <= rr & d;
          ANDC: rr <= rr & ~d;
          OR:   rr <= rr | d;
          ORC:  rr <= rr | ~d;
          XNOR: rr <= ~(rr ^ d);
          STO: begin
            if (oen) begin
              data_out <= rr;
              write    <= 1'b1;
            end
          end
          STOC: begin
            if (oen) begin
              data_out <= ~rr;
              write    <= 1'b1;
            end
          end
          IEN: ien <= data_in[0];
          OEN: oen <= data_in[0];
          JMP: begin
            jmp <= 1'b1;
            pc  <= addr_in;
`ifdef ICU_WIDE_STACK_EN
            if (stack_full) stack_ovf <= 1'b1;
            else            sp        <= sp + SP_W'(1);
`endif
          end
          RTN: begin
            rtn <= 1'b1;
`ifdef ICU_WIDE_STACK_EN
            if (stack_empty) begin
              stack_unf <= 1'b1;
            end else begin
              pc <= stack_mem[pop_idx];
              sp <= pop_idx;
            end
`else
            skip <= 1'b1;
`endif
          end
          SKZ:  skip   <= (rr == '0);
          NOPF: flag_f <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icu_wide.sv
// Self-checking bench for icu_wide (WIDTH=4, PC_WIDTH=8, STACK_DEPTH=2).
// A queue-based reference model tracks the expected architectural state.
// Stack-dependent expectations follow ICU_WIDE_STACK_EN when it is defined
// for the compile.

module tb_icu_wide;
  import instructions::*;

  localparam int W  = 4;
  localparam int PW = 8;
  localparam int SD = 2;

  logic          clk;
  logic          rst;
  instruction_t  i;
  logic [PW-1:0] addr_in;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          write;
  logic [PW-1:0] pc;
  logic          jmp;
  logic          rtn;
  logic          flag_o;
  logic          flag_f;
  logic [W-1:0]  rr_out;
  logic          stack_ovf;
  logic          stack_unf;

  icu_wide #(.WIDTH(W), .PC_WIDTH(PW), .STACK_DEPTH(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .i         (i),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .write     (write),
    .pc        (pc),
    .jmp       (jmp),
    .rtn       (rtn),
    .flag_o    (flag_o),
    .flag_f    (flag_f),
    .rr_out    (rr_out),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int unsigned m_rr, m_dout, m_pc;
  bit          m_ien, m_oen, m_skip, m_ovf, m_unf;
  bit          m_write, m_jmp, m_rtn, m_fo, m_ff;
  int unsigned m_stack[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_dout = 0; m_pc = 0;
    m_ien = 0; m_oen = 0; m_skip = 0; m_ovf = 0; m_unf = 0;
    m_write = 0; m_jmp = 0; m_rtn = 0; m_fo = 0; m_ff = 0;
    m_stack.delete();
  endtask

  task automatic model_step(input instruction_t op, input int unsigned a, input int unsigned dat);
    int unsigned d;
    int unsigned nxt;
    nxt = (m_pc + 1) % (1 << PW);
    m_write = 0; m_jmp = 0; m_rtn = 0; m_fo = 0; m_ff = 0;
    if (m_skip) begin
      m_skip = 0;
      m_pc   = nxt;
      return;
    end
    d    = m_ien ? dat : 0;
    m_pc = nxt;
    case (op)
      NOPO: m_fo = 1;
      LD:   m_rr = d;
      LDC:  m_rr = (~d) & 15;
      AND:  m_rr = m_rr & d;
      ANDC: m_rr = m_rr & (~d) & 15;
      OR:   m_rr = m_rr | d;
      ORC:  m_rr = (m_rr | ~d) & 15;
      XNOR: m_rr = (~(m_rr ^ d)) & 15;
      STO:  if (m_oen) begin m_dout = m_rr; m_write = 1; end
      STOC: if (m_oen) begin m_dout = (~m_rr) & 15; m_write = 1; end
      IEN:  m_ien = dat[0];
      OEN:  m_oen = dat[0];
      JMP: begin
        m_jmp = 1;
`ifdef ICU_WIDE_STACK_EN
        if (m_stack.size() == SD) m_ovf = 1;
        else m_stack.push_back(nxt);
`endif
        m_pc = a % (1 << PW);
      end
      RTN: begin
        m_rtn = 1;
`ifdef ICU_WIDE_STACK_EN
        if (m_stack.size() == 0) m_unf = 1;
        else m_pc = m_stack.pop_back();
`else
        m_skip = 1;
`endif
      end
      SKZ:  m_skip = (m_rr == 0);
      NOPF: m_ff = 1;
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rr"},    32'(rr_out),    m_rr);
    check({tag, ".dout"},  32'(data_out),  m_dout);
    check({tag, ".pc"},    32'(pc),        m_pc);
    check({tag, ".write"}, 32'(write),     32'(m_write));
    check({tag, ".jmp"},   32'(jmp),       32'(m_jmp));
    check({tag, ".rtn"},   32'(rtn),       32'(m_rtn));
    check({tag, ".fo"},    32'(flag_o),    32'(m_fo));
    check({tag, ".ff"},    32'(flag_f),    32'(m_ff));
    check({tag, ".ovf"},   32'(stack_ovf), 32'(m_ovf));
    check({tag, ".unf"},   32'(stack_unf), 32'(m_unf));
  endtask

  // Called with time just past a rising edge; returns the same way.
  task automatic step(input instruction_t op, input int unsigned a, input int unsigned dat);
    i       = op;
    addr_in = PW'(a);
    data_in = W'(dat);
    @(posedge clk);
    model_step(op, a, dat);
    #1;
    check_all(op.name());
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, holds over an
  // edge, then releases away from the edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
  endtask

  int unsigned p0;

  initial begin
    rst     = 1'b0;
    i       = NOPO;
    addr_in = '0;
    data_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // IEN gating of logic ops
    step(IEN, 0, 1);
    step(LD, 0, 4'b1010);
    check("ld_rr", 32'(rr_out), 32'hA);
    step(IEN, 0, 0);
    step(OR, 0, 4'b0101);
    check("or_gated_rr", 32'(rr_out), 32'hA);

    // OEN gating of stores
    step(OEN, 0, 1);
    step(STOC, 0, 0);
    check("stoc_dout", 32'(data_out), 32'h5);
    check("stoc_write", 32'(write), 1);
    step(NOPO, 0, 0);
    check("write_pulse_end", 32'(write), 0);
    step(OEN, 0, 0);
    step(STO, 0, 0);
    check("sto_off_write", 32'(write), 0);
    check("sto_off_dout", 32'(data_out), 32'h5);

    // SKZ taken and not taken
    step(IEN, 0, 1);
    p0 = m_pc;
    step(LD, 0, 0);
    step(SKZ, 0, 0);
    step(LD, 0, 4'hF);
    check("skz_rr", 32'(rr_out), 0);
    check("skz_pc", 32'(pc), (p0 + 3) % 256);
    step(LD, 0, 1);
    step(SKZ, 0, 0);
    step(LD, 0, 4'hF);
    check("skz_nz_rr", 32'(rr_out), 32'hF);

    // JMP / RTN from pc=5
    do_reset();
    for (int k = 0; k < 5; k++) step(NOPO, 0, 0);
    check("pc5", 32'(pc), 5);
    step(JMP, 8'h20, 0);
    check("jmp_pc", 32'(pc), 32'h20);
    check("jmp_pulse", 32'(jmp), 1);
    step(RTN, 0, 0);
    check("rtn_pulse", 32'(rtn), 1);
`ifdef ICU_WIDE_STACK_EN
    check("rtn_pc", 32'(pc), 6);

    // Nested jumps overflow the 2-deep stack; returns then underflow
    step(JMP, 8'h40, 0);
    step(JMP, 8'h50, 0);
    check("ovf_before", 32'(stack_ovf), 0);
    step(JMP, 8'h60, 0);
    check("ovf_third", 32'(stack_ovf), 1);
    check("ovf_pc", 32'(pc), 32'h60);
    step(RTN, 0, 0);
    check("rtn1_pc", 32'(pc), 32'h41);
    step(RTN, 0, 0);
    check("rtn2_pc", 32'(pc), 32'h07);
    check("unf_before", 32'(stack_unf), 0);
    step(RTN, 0, 0);
    check("rtn3_pc", 32'(pc), 32'h08);
    check("unf_third", 32'(stack_unf), 1);
    step(NOPO, 0, 0);
    check("ovf_sticky", 32'(stack_ovf), 1);
    check("unf_sticky", 32'(stack_unf), 1);
`else
    check("rtn_pc_nostack", 32'(pc), 32'h21);
`endif

    // Reset while a skip is armed
    step(IEN, 0, 1);
    step(LD, 0, 0);
    step(SKZ, 0, 0);
    do_reset();
    check("rst_skip_pc", 32'(pc), 0);
    check("rst_skip_rr", 32'(rr_out), 0);
    step(NOPF, 0, 0);
    check("post_rst_exec", 32'(flag_f), 1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(instruction_t'(4'($urandom_range(0, 15))), $urandom_range(0, 255),
             $urandom_range(0, 15));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
